memory_stage: RTL and testbench

- Y86-64 memory stage sitting directly downstream of the execute stage; consumes icode, valE, valA, valP and performs the data-memory read or write each instruction requires.
- Contains the data memory (word array), a small handshake FSM with single-cycle write and two-cycle read latency, and status generation (AOK/HLT/ADR/INS).
- Presents valM, the pass-through fields and a status code to the write-back stage over a valid/ready interface.
- Sticky halt once any non-AOK status is produced.

---
 rtl/memory_stage.sv | 145 ++++++++++++++
 tb/tb_memory_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage: data memory, read/write handshake FSM, status generation
module memory_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    icode,
  input  logic [63:0]   valE,
  input  logic [63:0]   valA,
  input  logic [63:0]   valP,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [63:0]   ld_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_icode,
  output logic [63:0]   out_valE,
  output logic [63:0]   valM,
  output logic [2:0]    stat,
  output logic          halted
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_OUT} state_t;

  state_t        r_state;
  logic          r_out_valid;
  logic [3:0]    r_out_icode;
  logic [63:0]   r_out_valE;
  logic [63:0]   r_valM;
  logic [2:0]    r_stat;
  logic          r_halted;
  logic [AW-1:0] r_rd_idx;
  logic [63:0]   r_mem [DEPTH];

  logic          w_is_rd;
  logic          w_is_wr;
  logic          w_is_mem;
  logic [63:0]   w_addr;
  logic [63:0]   w_wdata;
  logic          w_adr_err;
  logic [2:0]    w_stat;
  logic          w_accept;
  logic          w_req_wr;
  logic          w_pre_wr;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [63:0]   w_mem_din;

  always_comb begin
    w_is_rd = 1'b0;
    w_is_wr = 1'b0;
    case (icode)
      4'h4, 4'h8, 4'hA: w_is_wr = 1'b1;
      4'h5, 4'h9, 4'hB: w_is_rd = 1'b1;
      default: ;
    endcase
  end

  assign w_is_mem  = w_is_rd | w_is_wr;
  assign w_addr    = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
  assign w_wdata   = (icode == 4'h8) ? valP : valA;
  // Upper-bits compare keeps huge addresses from aliasing back into the array.
  assign w_adr_err = w_is_mem && ((w_addr[2:0] != 3'b000) || (w_addr[63:3] >= 61'(DEPTH)));

  always_comb begin
    w_stat = STAT_AOK;
    if (icode > 4'hB)      w_stat = STAT_INS;
    else if (icode == 4'h0) w_stat = STAT_HLT;
    else if (w_adr_err)     w_stat = STAT_ADR;
  end

  assign in_ready = (r_state == S_IDLE) && !r_halted;
  assign w_accept = in_valid && in_ready;
  assign w_req_wr = w_accept && w_is_wr && (w_stat == STAT_AOK);
  assign w_pre_wr = ld_en && !in_valid && (r_state == S_IDLE);

  assign w_mem_we  = rst_n && (w_req_wr || w_pre_wr);
  assign w_mem_idx = w_req_wr ? w_addr[AW+2:3] : ld_addr;
  assign w_mem_din = w_req_wr ? w_wdata : ld_data;

  // Memory has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_icode <= 4'h0;
      r_out_valE  <= 64'h0;
      r_valM      <= 64'h0;
      r_stat      <= STAT_AOK;
      r_halted    <= 1'b0;
      r_rd_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_out_icode <= icode;
            r_out_valE  <= valE;
            r_valM      <= 64'h0;
            r_stat      <= w_stat;
            r_rd_idx    <= w_addr[AW+2:3];
            if (w_is_rd && w_stat == STAT_AOK) begin
              r_state <= S_RD_WAIT;
            end else begin
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end
          end
        end
        S_RD_WAIT: begin
          r_valM      <= r_mem[r_rd_idx];
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            if (r_stat != STAT_AOK) r_halted <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_icode = r_out_icode;
  assign out_valE  = r_out_valE;
  assign valM      = r_valM;
  assign stat      = r_stat;
  assign halted    = r_halted;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage
module tb_memory_stage;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    icode = 4'h0;
  logic [63:0]   valE = 64'h0;
  logic [63:0]   valA = 64'h0;
  logic [63:0]   valP = 64'h0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [63:0]   ld_data = 64'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_icode;
  logic [63:0]   out_valE;
  logic [63:0]   valM;
  logic [2:0]    stat;
  logic          halted;

  memory_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .valE(valE), .valA(valA), .valP(valP),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_valE(out_valE), .valM(valM), .stat(stat), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ic;
    logic [63:0] e;
    logic [63:0] m;
    logic [2:0]  s;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [63:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input logic [63:0] exp_m, input logic [2:0] exp_s,
                       input int exp_lat);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("in_ready_idle", {63'h0, in_ready}, 64'h1);
    icode = ic; valE = e; valA = a; valP = p; in_valid = 1'b1;
    sb.push_back('{ic, e, exp_m, exp_s, exp_lat});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    exp_t x;
    int lat = 1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    x = sb.pop_front();
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(x.lat));
    check_eq("out_icode", {60'h0, out_icode}, {60'h0, x.ic});
    check_eq("out_valE", out_valE, x.e);
    check_eq("valM", valM, x.m);
    check_eq("stat", {61'h0, stat}, {61'h0, x.s});
    for (int i = 0; i < hold; i++) begin
      check_eq("bp_out_valid", {63'h0, out_valid}, 64'h1);
      check_eq("bp_in_ready", {63'h0, in_ready}, 64'h0);
      check_eq("bp_valM", valM, x.m);
      check_eq("bp_stat", {61'h0, stat}, {61'h0, x.s});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic check_halted();
    @(negedge clk);
    check_eq("halted_set", {63'h0, halted}, 64'h1);
    check_eq("halted_in_ready", {63'h0, in_ready}, 64'h0);
    icode = 4'h6; valE = 64'h1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("halted_ignores_req", {63'h0, out_valid}, 64'h0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check_eq("rst_stat", {61'h0, stat}, 64'h1);
    check_eq("rst_halted", {63'h0, halted}, 64'h0);
    check_eq("rst_in_ready", {63'h0, in_ready}, 64'h1);
    check_eq("rst_out_icode", {60'h0, out_icode}, 64'h0);
    check_eq("rst_valM", valM, 64'h0);

    preload(8'd2, 64'h1122334455667788);
    preload(8'd0, 64'h0000_0000_0000_0BAD);
    preload(8'd255, 64'h0F0F_0F0F_0F0F_0F0F);

    issue(4'h5, 64'h10, 64'h0, 64'h0, 64'h1122334455667788, 3'd1, 2); collect(0);
    issue(4'h4, 64'h18, 64'hDEAD, 64'h0, 64'h0, 3'd1, 1);             collect(0);
    issue(4'h5, 64'h18, 64'h0, 64'h0, 64'hDEAD, 3'd1, 2);             collect(0);
    issue(4'hA, 64'h20, 64'h5, 64'h0, 64'h0, 3'd1, 1);                collect(0);
    issue(4'hB, 64'h28, 64'h20, 64'h0, 64'h5, 3'd1, 2);               collect(0);
    issue(4'h8, 64'h30, 64'h0, 64'h47, 64'h0, 3'd1, 1);               collect(0);
    issue(4'h9, 64'h38, 64'h30, 64'h0, 64'h47, 3'd1, 2);              collect(0);
    issue(4'h6, 64'h9, 64'h0, 64'h0, 64'h0, 3'd1, 1);                 collect(0);
    issue(4'h6, 64'h77, 64'h0, 64'h0, 64'h0, 3'd1, 1);                collect(5);
    issue(4'h5, 64'h30, 64'h0, 64'h0, 64'h47, 3'd1, 2);               collect(3);

    // Preload colliding with an accepted request must be dropped.
    ld_en = 1'b1; ld_addr = 8'd2; ld_data = 64'h9999;
    issue(4'h6, 64'h3, 64'h0, 64'h0, 64'h0, 3'd1, 1);
    ld_en = 1'b0;
    collect(0);
    issue(4'h5, 64'h10, 64'h0, 64'h0, 64'h1122334455667788, 3'd1, 2); collect(0);

    issue(4'h5, 64'h13, 64'h0, 64'h0, 64'h0, 3'd3, 1); collect(0);
    check_halted();
    do_reset();
    issue(4'h4, 64'(8 * DEPTH), 64'hFFFF, 64'h0, 64'h0, 3'd3, 1); collect(0);
    check_halted();
    do_reset();
    issue(4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF, 64'h0, 64'h0, 3'd3, 1); collect(0);
    do_reset();
    issue(4'h0, 64'h10, 64'h0, 64'h0, 64'h0, 3'd2, 1); collect(0);
    check_halted();
    do_reset();
    issue(4'hC, 64'h10, 64'h0, 64'h0, 64'h0, 3'd4, 1); collect(0);
    do_reset();
    issue(4'h5, 64'h0, 64'h0, 64'h0, 64'h0000_0000_0000_0BAD, 3'd1, 2); collect(0);
    issue(4'h5, 64'h7F8, 64'h0, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 3'd1, 2); collect(0);

    @(negedge clk);
    icode = 4'h5; valE = 64'h10; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_eq("rdwait_no_valid", {63'h0, out_valid}, 64'h0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rdrst_out_valid", {63'h0, out_valid}, 64'h0);
    check_eq("rdrst_stat", {61'h0, stat}, 64'h1);
    check_eq("rdrst_halted", {63'h0, halted}, 64'h0);
    check_eq("rdrst_in_ready", {63'h0, in_ready}, 64'h1);
    repeat (2) begin
      @(negedge clk);
      check_eq("rdrst_dropped", {63'h0, out_valid}, 64'h0);
    end
    issue(4'h5, 64'h18, 64'h0, 64'h0, 64'hDEAD, 3'd1, 2); collect(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
